// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner.
//   state_t                 - debounce FSM encoding; x == state[1]
//   DEFAULT_DEBOUNCE_CYCLES - 10 ms at the 50 MHz board clock
//   cnt_width()             - debounce counter width, never below 1
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  function automatic int cnt_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_conditioner_sync.sv
// Plain flop chain that brings an asynchronous level into the clk domain.
//   clk   - destination clock
//   reset - async active-high, clears every stage
//   d     - asynchronous input
//   q     - synchronized output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // No logic between stages so each flop gets a full cycle to resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes and debounces a raw button level into a clean level x with
// single-cycle edge strobes.
//   clk     - system clock
//   reset   - async active-high reset
//   btn_raw - raw, bouncy, asynchronous button level
//   x       - debounced level (registered)
//   x_rise  - one-cycle pulse on x 0->1 (registered)
//   x_fall  - one-cycle pulse on x 1->0 (registered)
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic x,
  output logic x_rise,
  output logic x_fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          x_n, rise_n, fall_n;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE_LOW;
      cnt    <= '0;
      x      <= 1'b0;
      x_rise <= 1'b0;
      x_fall <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      x      <= x_n;
      x_rise <= rise_n;
      x_fall <= fall_n;
    end
  end

  // The counter only advances in a WAIT state and stops at CNT_TERM, where
  // the change is accepted, so it can never wrap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          state_n = WAIT_HIGH;
          cnt_n   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_n = IDLE_LOW;
        end else if (cnt == CNT_TERM) begin
          state_n = IDLE_HIGH;
          x_n     = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_n = WAIT_LOW;
          cnt_n   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_n = IDLE_HIGH;
        end else if (cnt == CNT_TERM) begin
          state_n = IDLE_LOW;
          x_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      // Corrupted state register: fall back to a known-low idle, no strobe.
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
        x_n     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic x, x_rise, x_fall;

  int total = 0;
  int bad   = 0;

  // Reference model: s is btn_raw as sampled SYNC edges earlier; x flips
  // once s has disagreed with x on DEB+1 consecutive edges.
  bit m_pipe [SYNC];
  bit m_x, m_rise, m_fall;
  int m_run;

  button_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .x       (x),
    .x_rise  (x_rise),
    .x_fall  (x_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    m_x = 0; m_rise = 0; m_fall = 0; m_run = 0;
  endtask

  task automatic model_edge();
    bit s;
    s = m_pipe[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = btn_raw;
    m_rise = 0; m_fall = 0;
    if (s != m_x) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_x = s;
        if (s) m_rise = 1; else m_fall = 1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // One clock edge, then compare all outputs against the model.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk({tag, ".x"},    x,      m_x);
    chk({tag, ".rise"}, x_rise, m_rise);
    chk({tag, ".fall"}, x_fall, m_fall);
    chk({tag, ".excl"}, x_rise & x_fall, 1'b0);
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    int len;
    bit lvl;

    btn_raw = 1'b1;
    reset   = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst.x", x, 1'b0);
    chk("rst.rise", x_rise, 1'b0);
    chk("rst.fall", x_fall, 1'b0);
    btn_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) tick("idle");

    // Clean press: x rises exactly after edge n+6.
    btn_raw = 1'b1;
    rise_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick("press");
      chk("press.early", x, 1'b0);
    end
    tick("press");
    chk("press.x6", x, 1'b1);
    chk("press.rise6", x_rise, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick("press.hold");
      rise_cnt += x_rise;
    end
    chk("press.onepulse", rise_cnt == 0, 1'b1);

    // Clean release: x falls exactly after edge m+6.
    btn_raw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick("rel");
      chk("rel.early", x, 1'b1);
    end
    tick("rel");
    chk("rel.x6", x, 1'b0);
    chk("rel.fall6", x_fall, 1'b1);
    repeat (6) tick("rel.hold");

    // Bounce: high 2, low 1, high 2, low -> no change.
    rise_cnt = 0;
    btn_raw = 1'b1; repeat (2) tick("bnc");
    btn_raw = 1'b0; tick("bnc");
    btn_raw = 1'b1; repeat (2) tick("bnc");
    btn_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick("bnc");
      rise_cnt += x_rise + x;
    end
    chk("bnc.nochange", rise_cnt == 0, 1'b1);

    // Reset mid-count with button held.
    btn_raw = 1'b1;
    repeat (4) tick("rmid");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 chk("rmid.x", x, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    rise_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick("rmid.after");
      rise_cnt += x_rise;
    end
    chk("rmid.x_final", x, 1'b1);
    chk("rmid.onerise", rise_cnt == 1, 1'b1);

    // Async reset while x is high, checked without a clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("arst.x", x, 1'b0);
    chk("arst.rise", x_rise, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    btn_raw = 1'b0;

    // Randomized bounce/hold runs.
    rise_cnt = 0; fall_cnt = 0;
    for (int r = 0; r < 400; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = (r % 3 == 0) ? int'($urandom_range(6, 14)) : int'($urandom_range(1, 5));
      btn_raw = lvl;
      for (int k = 0; k < len; k++) begin
        tick("rand");
        rise_cnt += x_rise;
        fall_cnt += x_fall;
      end
    end
    chk("rand.activity", (rise_cnt > 0) && (fall_cnt > 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
